// File: rtl/biss_master.sv
// BiSS-C master for one encoder channel: generates MA, sequences one frame per
// trigger, checks the CRC and reports position plus sticky STATUS.
module biss_master #(
    parameter int unsigned ACK_MAX  = 16,
    parameter int unsigned STOP_MAX = 4096
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  BITS,
    input  logic [15:0] CLK_DIV,
    input  logic        trig_i,
    output logic [31:0] STATUS,
    input  logic        STATUS_RSTB,
    output logic        biss_ma_o,
    input  logic        biss_slo_i,
    output logic [31:0] posn_o,
    output logic        posn_valid_o,
    output logic        busy_o
);
    localparam int unsigned CNT_MAX = (ACK_MAX > 32) ? ACK_MAX : 32;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned STOP_W  = $clog2(STOP_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACK   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_CDS   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_EW    = 3'd5;
    localparam logic [2:0] S_CRC   = 3'd6;
    localparam logic [2:0] S_STOP  = 3'd7;

    logic [2:0]        r_state, w_state;
    logic [15:0]       r_div, w_div;
    logic [5:0]        r_bits, w_bits;
    logic [15:0]       r_hcnt, w_hcnt;
    logic              r_ma, w_ma;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [STOP_W-1:0] r_stop, w_stop;
    logic [16:0]       r_hi, w_hi;
    logic [31:0]       r_shift, w_shift;
    logic [5:0]        r_crc, w_crc;
    logic [4:0]        r_rx, w_rx;
    logic [31:0]       r_posn, w_posn;
    logic              r_valid, w_valid;
    logic              r_busy;
    logic [5:0]        r_flags, w_flags, w_set;
    logic [15:0]       r_good, w_good;
    logic              w_inc;

    logic [15:0] w_div_in;
    logic [5:0]  w_bits_in;
    logic        w_clocking, w_tick, w_sample, w_fb;
    logic [5:0]  w_crc_step;
    logic [31:0] w_mask, w_ext;
    logic [16:0] w_hi_full;

    // Frame-invariant helpers: clamped settings, MA tick, CRC step, sign extension
    always_comb begin
        w_div_in   = (CLK_DIV < 16'd2) ? 16'd2 : CLK_DIV;
        w_bits_in  = (BITS == 8'd0) ? 6'd1 : ((BITS > 8'd32) ? 6'd32 : BITS[5:0]);
        w_clocking = (r_state != S_IDLE) && (r_state != S_STOP);
        w_tick     = (r_hcnt == (r_div - 16'd1));
        w_sample   = w_tick && r_ma;
        w_fb       = r_crc[5] ^ biss_slo_i;
        w_crc_step = {r_crc[4:0], w_fb} ^ {4'd0, w_fb, 1'b0};
        w_mask     = 32'hFFFF_FFFF >> (6'd32 - r_bits);
        w_ext      = (r_shift & w_mask) | ({32{r_shift[5'(r_bits - 6'd1)]}} & ~w_mask);
        w_hi_full  = 17'({r_div, 1'b0}) - 17'd1;
    end

    // Next-state and datapath
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bits  = r_bits;
        w_hcnt  = r_hcnt;
        w_ma    = r_ma;
        w_cnt   = r_cnt;
        w_stop  = r_stop;
        w_hi    = r_hi;
        w_shift = r_shift;
        w_crc   = r_crc;
        w_rx    = r_rx;
        w_posn  = r_posn;
        w_valid = 1'b0;
        w_set   = '0;
        w_inc   = 1'b0;

        if (trig_i && (r_state != S_IDLE)) w_set[5] = 1'b1;

        if (w_clocking) begin
            if (w_tick) begin
                w_hcnt = '0;
                w_ma   = ~r_ma;
            end else begin
                w_hcnt = r_hcnt + 16'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_ma = 1'b1;
                if (trig_i) begin
                    w_state = S_ACK;
                    w_div   = w_div_in;
                    w_bits  = w_bits_in;
                    w_hcnt  = w_div_in - 16'd1;
                    w_cnt   = '0;
                    w_shift = '0;
                    w_crc   = '0;
                    w_rx    = '0;
                end
            end
            S_ACK: if (w_sample) begin
                if (!biss_slo_i) begin
                    w_state = S_START;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_W'(ACK_MAX - 1)) begin
                    w_set[1] = 1'b1;
                    w_state  = S_STOP;
                    w_stop   = '0;
                    w_hi     = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_START: if (w_sample) begin
                if (biss_slo_i) begin
                    w_state = S_CDS;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_W'(ACK_MAX - 1)) begin
                    w_set[1] = 1'b1;
                    w_state  = S_STOP;
                    w_stop   = '0;
                    w_hi     = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_CDS: if (w_sample) begin
                w_state = S_DATA;
                w_cnt   = '0;
            end
            S_DATA: if (w_sample) begin
                w_shift = {r_shift[30:0], biss_slo_i};
                w_crc   = w_crc_step;
                if (r_cnt == CNT_W'(r_bits - 6'd1)) begin
                    w_state = S_EW;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_EW: if (w_sample) begin
                w_crc = w_crc_step;
                if (r_cnt == '0) begin
                    w_set[3] = ~biss_slo_i;
                    w_cnt    = CNT_W'(1);
                end else begin
                    w_set[4] = ~biss_slo_i;
                    w_state  = S_CRC;
                    w_cnt    = '0;
                end
            end
            S_CRC: if (w_sample) begin
                w_rx = {r_rx[3:0], biss_slo_i};
                if (r_cnt == CNT_W'(5)) begin
                    w_state = S_STOP;
                    w_stop  = '0;
                    w_hi    = '0;
                    // Received CRC is sent inverted
                    if (~{r_rx, biss_slo_i} == r_crc) begin
                        w_posn  = w_ext;
                        w_valid = 1'b1;
                        w_inc   = 1'b1;
                    end else begin
                        w_set[0] = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Finish the current low phase, then hold MA high for a full period
                if (!r_ma) begin
                    if (w_tick) begin
                        w_ma   = 1'b1;
                        w_hcnt = '0;
                    end else begin
                        w_hcnt = r_hcnt + 16'd1;
                    end
                end else if (r_hi < w_hi_full) begin
                    w_hi = r_hi + 17'd1;
                end
                if (r_stop != STOP_W'(STOP_MAX - 1)) w_stop = r_stop + STOP_W'(1);

                if (biss_slo_i && r_ma && (r_hi >= w_hi_full)) begin
                    w_state = S_IDLE;
                end else if (!biss_slo_i && (r_stop == STOP_W'(STOP_MAX - 1))) begin
                    w_set[2] = 1'b1;
                    w_state  = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // A set on the same cycle as a clear survives the clear
        if (STATUS_RSTB) begin
            w_flags = w_set;
            w_good  = w_inc ? 16'd1 : 16'd0;
        end else begin
            w_flags = r_flags | w_set;
            w_good  = r_good + 16'(w_inc);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bits  <= '0;
            r_hcnt  <= '0;
            r_ma    <= 1'b1;
            r_cnt   <= '0;
            r_stop  <= '0;
            r_hi    <= '0;
            r_shift <= '0;
            r_crc   <= '0;
            r_rx    <= '0;
            r_posn  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_flags <= '0;
            r_good  <= '0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bits  <= w_bits;
            r_hcnt  <= w_hcnt;
            r_ma    <= w_ma;
            r_cnt   <= w_cnt;
            r_stop  <= w_stop;
            r_hi    <= w_hi;
            r_shift <= w_shift;
            r_crc   <= w_crc;
            r_rx    <= w_rx;
            r_posn  <= w_posn;
            r_valid <= w_valid;
            r_busy  <= (w_state != S_IDLE);
            r_flags <= w_flags;
            r_good  <= w_good;
        end
    end

    assign biss_ma_o    = r_ma;
    assign posn_o       = r_posn;
    assign posn_valid_o = r_valid;
    assign busy_o       = r_busy;
    assign STATUS       = {r_good, 10'd0, r_flags};

endmodule

// File: tb/tb_biss_master.sv
// Directed bench for biss_master: an encoder model answers each MA fall with
// the next frame bit; expected positions and STATUS words are hand-computed.
module tb_biss_master;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  BITS;
    logic [15:0] CLK_DIV;
    logic        trig_i;
    logic        STATUS_RSTB;
    logic        biss_slo_i;
    logic [31:0] STATUS;
    logic        biss_ma_o;
    logic [31:0] posn_o;
    logic        posn_valid_o;
    logic        busy_o;

    int n_vec = 0;
    int n_bad = 0;

    // Results of the last run_frame call
    int rf_falls, rf_pulses, rf_first, rf_badint, rf_last, rf_slohi, rf_done;

    logic [63:0] seq;
    int          seq_len;

    always #5 clk = ~clk;

    biss_master #(.ACK_MAX(16), .STOP_MAX(4096)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .BITS         (BITS),
        .CLK_DIV      (CLK_DIV),
        .trig_i       (trig_i),
        .STATUS       (STATUS),
        .STATUS_RSTB  (STATUS_RSTB),
        .biss_ma_o    (biss_ma_o),
        .biss_slo_i   (biss_slo_i),
        .posn_o       (posn_o),
        .posn_valid_o (posn_valid_o),
        .busy_o       (busy_o)
    );

    // x^6+x+1 remainder, one bit at a time, kept in an int
    function automatic int crc_bit(input int c, input logic b);
        int fb;
        int r;
        fb = ((c >> 5) & 1) ^ (b ? 1 : 0);
        r  = (c << 1) & 63;
        if (fb != 0) r = r ^ 3;
        return r;
    endfunction

    // Encoder answer per MA fall: idle-1, ACK 0, START 1, CDS 0, data, nE, nW, ~CRC
    task automatic build_seq(input logic [31:0] data, input int bits, input logic ne,
                             input logic nw, input logic [5:0] flip);
        int c;
        int n;
        logic [5:0] tx;
        seq = '1;
        c = 0;
        seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0;
        n = 4;
        for (int i = bits - 1; i >= 0; i--) begin
            seq[n] = data[i]; n++; c = crc_bit(c, data[i]);
        end
        seq[n] = ne; n++; c = crc_bit(c, ne);
        seq[n] = nw; n++; c = crc_bit(c, nw);
        tx = ~6'(c) ^ flip;
        for (int i = 5; i >= 0; i--) begin
            seq[n] = tx[i]; n++;
        end
        seq_len = n;
    endtask

    task automatic run_frame(input int period, input int hold_lo, input int trig_at, input int abort_at);
        int   idx;
        int   lo_cnt;
        int   prev_fall;
        logic prev_ma;
        idx = 0; lo_cnt = 0; prev_fall = -1;
        rf_falls = 0; rf_pulses = 0; rf_first = -1; rf_badint = 0;
        rf_last = -1; rf_slohi = -1; rf_done = -1;
        @(negedge clk);
        trig_i = 1'b1;
        biss_slo_i = seq[0];
        @(negedge clk);
        trig_i = 1'b0;
        prev_ma = biss_ma_o;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            trig_i = (cyc == trig_at);
            if (prev_ma && !biss_ma_o) begin
                rf_falls++;
                if (rf_first < 0) rf_first = cyc;
                if (prev_fall >= 0 && (cyc - prev_fall) != period) rf_badint++;
                prev_fall = cyc;
                rf_last = cyc;
                idx++;
                biss_slo_i = (idx < seq_len) ? seq[idx] : 1'b0;
            end else if (idx >= seq_len) begin
                if (lo_cnt < hold_lo) lo_cnt++;
                else if (!biss_slo_i) begin
                    biss_slo_i = 1'b1;
                    rf_slohi = cyc;
                end
            end
            if (posn_valid_o) rf_pulses++;
            if (cyc == abort_at) break;
            if (!busy_o) begin
                rf_done = cyc;
                break;
            end
            prev_ma = biss_ma_o;
            @(negedge clk);
        end
        trig_i = 1'b0;
        if (abort_at < 0) biss_slo_i = 1'b1;
    endtask

    task automatic pulse_rstb();
        @(negedge clk);
        STATUS_RSTB = 1'b1;
        @(negedge clk);
        STATUS_RSTB = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (biss_ma_o !== 1'b1) begin n_bad++; $display("FAIL reset_ma got %b exp 1", biss_ma_o); end
        n_vec++; if (posn_o !== 32'h0) begin n_bad++; $display("FAIL reset_posn got %h exp 00000000", posn_o); end
        n_vec++; if (posn_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", posn_valid_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_vec++; if (STATUS !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h exp 00000000", STATUS); end
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame32();
        BITS = 8'd32; CLK_DIV = 16'd4;
        build_seq(32'h1234_5678, 32, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, -1, -1);
        n_vec++; if (rf_first !== 1) begin n_bad++; $display("FAIL f32_first_fall got %0d exp 1", rf_first); end
        n_vec++; if (rf_badint !== 0) begin n_bad++; $display("FAIL f32_ma_period got %0d bad exp 0", rf_badint); end
        n_vec++; if (rf_falls !== 44) begin n_bad++; $display("FAIL f32_falls got %0d exp 44", rf_falls); end
        n_vec++; if (posn_o !== 32'h1234_5678) begin n_bad++; $display("FAIL f32_posn got %h exp 12345678", posn_o); end
        n_vec++; if (rf_pulses !== 1) begin n_bad++; $display("FAIL f32_pulses got %0d exp 1", rf_pulses); end
        n_vec++; if (STATUS !== 32'h0001_0000) begin n_bad++; $display("FAIL f32_status got %h exp 00010000", STATUS); end
        n_vec++; if (rf_slohi < 0 || rf_done !== rf_slohi + 1) begin n_bad++; $display("FAIL f32_busy_end got %0d exp %0d", rf_done, rf_slohi + 1); end
        n_vec++; if (biss_ma_o !== 1'b1) begin n_bad++; $display("FAIL f32_ma_idle got %b exp 1", biss_ma_o); end
    endtask

    task automatic test_sign_extend();
        BITS = 8'd24; CLK_DIV = 16'd4;
        build_seq(32'h00FF_F000, 24, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, -1, -1);
        n_vec++; if (posn_o !== 32'hFFFF_F000) begin n_bad++; $display("FAIL sx_neg got %h exp fffff000", posn_o); end
        build_seq(32'h007F_F000, 24, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, -1, -1);
        n_vec++; if (posn_o !== 32'h007F_F000) begin n_bad++; $display("FAIL sx_pos got %h exp 007ff000", posn_o); end
        n_vec++; if (STATUS !== 32'h0003_0000) begin n_bad++; $display("FAIL sx_status got %h exp 00030000", STATUS); end
        BITS = 8'd0;
        build_seq(32'h0000_0001, 1, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, -1, -1);
        n_vec++; if (posn_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sx_bits0 got %h exp ffffffff", posn_o); end
        n_vec++; if (rf_falls !== 13) begin n_bad++; $display("FAIL sx_bits0_falls got %0d exp 13", rf_falls); end
    endtask

    task automatic test_crc_error();
        BITS = 8'd24; CLK_DIV = 16'd4;
        build_seq(32'h0012_3456, 24, 1'b1, 1'b1, 6'b000100);
        run_frame(8, 20, -1, -1);
        n_vec++; if (STATUS !== 32'h0004_0001) begin n_bad++; $display("FAIL crc_status got %h exp 00040001", STATUS); end
        n_vec++; if (posn_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL crc_posn_held got %h exp ffffffff", posn_o); end
        n_vec++; if (rf_pulses !== 0) begin n_bad++; $display("FAIL crc_pulses got %0d exp 0", rf_pulses); end
        pulse_rstb();
        n_vec++; if (STATUS !== 32'h0) begin n_bad++; $display("FAIL rstb_clear got %h exp 00000000", STATUS); end
    endtask

    task automatic test_enc_flags();
        BITS = 8'd8; CLK_DIV = 16'd2;
        build_seq(32'h0000_0042, 8, 1'b0, 1'b0, 6'd0);
        run_frame(4, 20, -1, -1);
        n_vec++; if (STATUS !== 32'h0001_0018) begin n_bad++; $display("FAIL ew_status got %h exp 00010018", STATUS); end
        n_vec++; if (posn_o !== 32'h0000_0042) begin n_bad++; $display("FAIL ew_posn got %h exp 00000042", posn_o); end
        pulse_rstb();
    endtask

    task automatic test_ack_timeout();
        BITS = 8'd32; CLK_DIV = 16'd4;
        seq = '1; seq_len = 64;
        run_frame(8, 0, -1, -1);
        n_vec++; if (rf_falls !== 16) begin n_bad++; $display("FAIL ack_falls got %0d exp 16", rf_falls); end
        n_vec++; if (STATUS !== 32'h0000_0002) begin n_bad++; $display("FAIL ack_status got %h exp 00000002", STATUS); end
        n_vec++; if (rf_done < 0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL ack_busy got %b exp 0", busy_o); end
        n_vec++; if (rf_pulses !== 0) begin n_bad++; $display("FAIL ack_pulses got %0d exp 0", rf_pulses); end
        pulse_rstb();
    endtask

    task automatic test_stop_timeout();
        BITS = 8'd32; CLK_DIV = 16'd4;
        build_seq(32'h0F0F_0F0F, 32, 1'b1, 1'b1, 6'd0);
        run_frame(8, 5000, -1, -1);
        n_vec++; if (STATUS[5:0] !== 6'b000100) begin n_bad++; $display("FAIL stop_flags got %b exp 000100", STATUS[5:0]); end
        n_vec++; if (rf_done < 0 || (rf_done - rf_last) !== 4096) begin n_bad++; $display("FAIL stop_cycles got %0d exp 4096", rf_done - rf_last); end
        pulse_rstb();
    endtask

    task automatic test_overrun();
        BITS = 8'd32; CLK_DIV = 16'd4;
        build_seq(32'hA5A5_1234, 32, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, 20, -1);
        n_vec++; if (STATUS !== 32'h0001_0020) begin n_bad++; $display("FAIL ovr_status got %h exp 00010020", STATUS); end
        n_vec++; if (posn_o !== 32'hA5A5_1234) begin n_bad++; $display("FAIL ovr_posn got %h exp a5a51234", posn_o); end
        n_vec++; if (rf_falls !== 44) begin n_bad++; $display("FAIL ovr_falls got %0d exp 44", rf_falls); end
    endtask

    task automatic test_reset_mid_frame();
        BITS = 8'd32; CLK_DIV = 16'd4;
        build_seq(32'h5555_AAAA, 32, 1'b1, 1'b1, 6'd0);
        run_frame(8, 20, -1, 60);
        n_vec++; if (biss_ma_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL mid_pre got ma=%b busy=%b exp ma=0 busy=1", biss_ma_o, busy_o); end
        #3 reset_i = 1'b1;
        #1;
        n_vec++; if (biss_ma_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ma got %b exp 1", biss_ma_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b exp 0", busy_o); end
        n_vec++; if (posn_o !== 32'h0) begin n_bad++; $display("FAIL mid_rst_posn got %h exp 00000000", posn_o); end
        n_vec++; if (STATUS !== 32'h0) begin n_bad++; $display("FAIL mid_rst_status got %h exp 00000000", STATUS); end
        n_vec++; if (posn_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b exp 0", posn_valid_o); end
        biss_slo_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        BITS = 8'd16; CLK_DIV = 16'd1;
        build_seq(32'h0000_8001, 16, 1'b1, 1'b1, 6'd0);
        run_frame(4, 20, -1, -1);
        n_vec++; if (rf_badint !== 0) begin n_bad++; $display("FAIL post_ma_period got %0d bad exp 0", rf_badint); end
        n_vec++; if (posn_o !== 32'hFFFF_8001) begin n_bad++; $display("FAIL post_posn got %h exp ffff8001", posn_o); end
        n_vec++; if (STATUS !== 32'h0001_0000) begin n_bad++; $display("FAIL post_status got %h exp 00010000", STATUS); end
    endtask

    initial begin
        reset_i = 1'b1;
        BITS = 8'd32;
        CLK_DIV = 16'd4;
        trig_i = 1'b0;
        STATUS_RSTB = 1'b0;
        biss_slo_i = 1'b1;
        test_reset();
        test_frame32();
        test_sign_extend();
        test_crc_error();
        test_enc_flags();
        test_ack_timeout();
        test_stop_timeout();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/biss_master.md
Name: biss_master

Overview:
- Active BiSS-C master for one encoder channel: generates the MA clock, sequences a single-cycle BiSS frame per trigger, and checks the CRC.
- Extracts the BITS-wide position and reports sticky STATUS.
- Sits where a passive sniffer would otherwise listen: same BITS/STATUS/STATUS_RSTB/posn_o register model, so the two are interchangeable per encoder slot.

Parameters:
- ACK_MAX, 16, maximum MA periods waited for ACK and, separately, for the START bit.
- STOP_MAX, 4096, maximum clk_i cycles waited in STOP for SLO to return high.

Ports:
- clk_i  input  1  system clock; single clock domain.
- reset_i  input  1  asynchronous, active-high reset.
- BITS  input  8  position width; 1..32. 0 is treated as 1; >32 is treated as 32.
- CLK_DIV  input  16  MA half-period in clk_i cycles; values <2 are treated as 2.
- trig_i  input  1  single-cycle frame request.
- STATUS  output  32  sticky flags and frame counter.
- STATUS_RSTB  input  1  single-cycle strobe; clears STATUS.
- biss_ma_o  output  1  MA clock to encoder; idles high.
- biss_slo_i  input  1  SLO data from encoder; pre-synchronised, idles high.
- posn_o  output  32  last good position, sign-extended from BITS.
- posn_valid_o  output  1  one-cycle pulse when posn_o updates.
- busy_o  output  1  high while a frame is in progress (state not IDLE).

Behaviour:
- Reset (async, any time, including mid-frame):
  - State returns to IDLE.
  - biss_ma_o=1, posn_o=0, posn_valid_o=0, busy_o=0, STATUS=0, bit/timeout counters zeroed.
- MA generation:
  - Half-period counter runs only while clocking.
  - biss_ma_o first falls 1 cycle after trig_i is accepted.
  - Full period is 2*CLK_DIV cycles.
  - SLO is sampled on the last clk_i cycle of each MA-high phase, i.e. immediately before the falling edge.
  - CLK_DIV and BITS are latched when trig_i is accepted and held for the whole frame.
- States:
  - IDLE: MA high. trig_i -> ACK.
  - ACK: clocking. Sample 0 -> START. ACK_MAX samples without a 0 -> set STATUS[1] -> STOP.
  - START: clocking. Sample 1 -> CDS. ACK_MAX samples without a 1 -> set STATUS[1] -> STOP.
  - CDS: one bit sampled and discarded -> DATA.
  - DATA: BITS samples, MSB first, shifted into a 32-bit register -> EW.
  - EW: 2 samples, nE then nW (both active-low). nE=0 sets STATUS[3]; nW=0 sets STATUS[4] -> CRC.
  - CRC: 6 samples, received inverted -> STOP.
  - STOP:
    - MA held high; wait for SLO=1, plus at least one full MA period of MA high.
    - -> IDLE.
    - If STOP_MAX cycles elapse with SLO still 0: set STATUS[2] -> IDLE.
- CRC check:
  - Polynomial x^6+x+1 (0x43), initial value 0.
  - Computed over DATA bits then nE, nW, in transmission order.
  - Compared against the bitwise inverse of the received CRC.
  - Match: posn_o <= sign-extend(data[BITS-1:0]); posn_valid_o pulses for 1 cycle; STATUS[31:16] increments (wraps at 0xFFFF).
  - posn_o and posn_valid_o update on the cycle after the 6th CRC sample.
  - Mismatch: set STATUS[0]; posn_o is held.
  - A frame aborted by timeout never updates posn_o.
- trig_i while busy_o=1: ignored, sets STATUS[5] (overrun).
- STATUS map:
  - [0] crc_err, [1] ack_timeout, [2] stop_timeout, [3] enc_error, [4] enc_warning, [5] overrun.
  - [15:6] read as 0.
  - [31:16] good_frames.
- STATUS_RSTB clears all of STATUS.
  - Same-cycle set and clear: the set wins; a counter increment on that cycle leaves good_frames=1.
- Only the counters and the shift register are arithmetic: no saturation except as stated; widths are exact.

Test Plan:
- Encoder model, BITS=32, CLK_DIV=4, posn=0x12345678, nE=nW=1, correct CRC, one trig_i -> sequence:
  - biss_ma_o toggles every 4 cycles.
  - posn_o=0x12345678 with a single posn_valid_o pulse.
  - STATUS=0x00010000.
  - busy_o falls after SLO returns high.
- BITS=24, posn=0xFFF000, good CRC -> posn_o=0xFFFFF000. Then posn=0x7FF000 -> posn_o=0x007FF000.
- Corrupt 1 CRC bit -> STATUS[0]=1, posn_o unchanged, no posn_valid_o. Then STATUS_RSTB -> STATUS=0.
- SLO tied high -> exactly 16 MA periods in ACK, STATUS[1]=1, frame ends, busy_o=0.
- SLO held low after CRC for 5000 cycles -> STATUS[2]=1 after 4096 STOP cycles, then IDLE.
- trig_i mid-frame -> STATUS[5]=1, frame completes normally.
- reset_i pulsed mid-DATA -> biss_ma_o=1 and all outputs 0 asynchronously. A subsequent trig_i runs a clean frame.
